// File: rtl/host_mailbox_fifo_if.sv
// Core MMIO and host stream signals of the mailbox, bundled for port connection.
// master drives requests and host-side offers; slave is the mailbox itself.
interface host_mailbox_fifo_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        core_addr;
    logic              core_rd;
    logic              core_wr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;
    logic              host_rx_valid;
    logic [DATA_W-1:0] host_rx_data;
    logic              host_rx_ready;
    logic              host_tx_valid;
    logic [DATA_W-1:0] host_tx_data;
    logic              host_tx_ready;
    logic              rx_irq;

    modport master (
        output core_addr, core_rd, core_wr, core_wdata,
        output host_rx_valid, host_rx_data, host_tx_ready,
        input  core_rdata, core_rvalid, host_rx_ready, host_tx_valid, host_tx_data, rx_irq
    );

    modport slave (
        input  core_addr, core_rd, core_wr, core_wdata,
        input  host_rx_valid, host_rx_data, host_tx_ready,
        output core_rdata, core_rvalid, host_rx_ready, host_tx_valid, host_tx_data, rx_irq
    );
endinterface

// File: rtl/host_mailbox_fifo.sv
// MMIO mailbox: host->core RX FIFO, core->host TX FIFO, sticky OVF/UNDF,
// flush control and a registered RX level interrupt.

module host_mailbox_fifo_q #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    parameter  int LEVEL  = 1,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              at_level
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + CW'(1);
        else if (!do_push && do_pop)
            count_nxt = count - CW'(1);
    end

    // at_level is registered from the post-update count, so it tracks count with no lag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            at_level <= 1'b0;
        end else begin
            count    <= count_nxt;
            at_level <= (count_nxt >= CW'(LEVEL));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module host_mailbox_fifo #(
    parameter int DATA_W    = 32,
    parameter int RX_DEPTH  = 4,
    parameter int TX_DEPTH  = 4,
    parameter int RX_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    host_mailbox_fifo_if.slave   bus
);
    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam int TCW = $clog2(TX_DEPTH + 1);

    logic [DATA_W-1:0] rx_head, tx_head, status, rdata_nxt;
    logic [RCW-1:0]    rx_count;
    logic [TCW-1:0]    tx_count;
    logic rx_full, rx_empty, tx_full, tx_empty, rx_lvl, tx_lvl;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rd_rx, wr_tx, wr_ctrl, rx_flush, tx_flush, flag_clr;
    logic ovf, undf;

    assign rd_rx    = bus.core_rd && (bus.core_addr == 2'd0);
    assign wr_tx    = bus.core_wr && (bus.core_addr == 2'd2);
    assign wr_ctrl  = bus.core_wr && (bus.core_addr == 2'd3);
    assign rx_flush = wr_ctrl && bus.core_wdata[0];
    assign tx_flush = wr_ctrl && bus.core_wdata[1];
    assign flag_clr = wr_ctrl && bus.core_wdata[2];

    assign rx_push = bus.host_rx_valid && !rx_full;
    assign rx_pop  = rd_rx && !rx_empty;
    assign tx_push = wr_tx && !tx_full;
    assign tx_pop  = tx_lvl && bus.host_tx_ready;

    host_mailbox_fifo_q #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH), .LEVEL(RX_THRESH)) u_rx (
        .clk(clk), .rst_n(rst_n), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
        .wdata(bus.host_rx_data), .head(rx_head), .count(rx_count),
        .full(rx_full), .empty(rx_empty), .at_level(rx_lvl)
    );

    // LEVEL=1 makes at_level a registered !empty, which is exactly host_tx_valid
    host_mailbox_fifo_q #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH), .LEVEL(1)) u_tx (
        .clk(clk), .rst_n(rst_n), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
        .wdata(bus.core_wdata), .head(tx_head), .count(tx_count),
        .full(tx_full), .empty(tx_empty), .at_level(tx_lvl)
    );

    assign bus.host_rx_ready = !rx_full;
    assign bus.host_tx_valid = tx_lvl;
    assign bus.host_tx_data  = tx_head;
    assign bus.rx_irq        = rx_lvl;

    always_comb begin
        status        = '0;
        status[23:16] = 8'(tx_count);
        status[15:8]  = 8'(rx_count);
        status[5]     = ovf;
        status[4]     = undf;
        status[3]     = tx_full;
        status[2]     = tx_empty;
        status[1]     = rx_full;
        status[0]     = !rx_empty;
    end

    always_comb begin
        rdata_nxt = '0;
        case (bus.core_addr)
            2'd0:    rdata_nxt = rx_head;
            2'd1:    rdata_nxt = status;
            default: rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.core_rdata  <= '0;
            bus.core_rvalid <= 1'b0;
            ovf             <= 1'b0;
            undf            <= 1'b0;
        end else begin
            bus.core_rvalid <= bus.core_rd;
            if (bus.core_rd) bus.core_rdata <= rdata_nxt;
            ovf  <= (wr_tx && tx_full) | (ovf & ~flag_clr);
            undf <= (rd_rx && rx_empty) | (undf & ~flag_clr);
        end
    end
endmodule

// File: tb/tb_host_mailbox_fifo.sv
// Randomised and directed bench for host_mailbox_fifo against a queue-based model.
module tb_host_mailbox_fifo;
    localparam int DW = 32, RXD = 4, TXD = 4, THR = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    host_mailbox_fifo_if #(.DATA_W(DW)) bus ();

    host_mailbox_fifo #(.DATA_W(DW), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .RX_THRESH(THR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    int vectors = 0, miscompares = 0;
    logic [DW-1:0] rx_q[$], tx_q[$];
    logic          m_ovf, m_undf, m_irq, m_rvalid;
    logic [DW-1:0] m_rdata;

    function automatic logic [DW-1:0] m_status();
        int r, t;
        r = rx_q.size();
        t = tx_q.size();
        return DW'((t << 16) | (r << 8) | (int'(m_ovf) << 5) | (int'(m_undf) << 4) |
                   (int'(t == TXD) << 3) | (int'(t == 0) << 2) | (int'(r == RXD) << 1) | int'(r != 0));
    endfunction

    task automatic idle();
        bus.core_addr = 2'd0; bus.core_rd = 1'b0; bus.core_wr = 1'b0; bus.core_wdata = '0;
        bus.host_rx_valid = 1'b0; bus.host_rx_data = '0; bus.host_tx_ready = 1'b0;
    endtask

    task automatic model_reset();
        rx_q.delete(); tx_q.delete();
        m_ovf = 0; m_undf = 0; m_irq = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // Advance one clock and apply the mailbox rules to the model from the inputs held this cycle.
    task automatic step();
        logic rv, push_rx, pop_rx, undf_s, push_tx, pop_tx, ovf_s, fl_rx, fl_tx, clr;
        logic [DW-1:0] rdv, hd, wd;
        rv = bus.core_rd;
        rdv = '0;
        if (bus.core_addr == 2'd0) rdv = (rx_q.size() > 0) ? rx_q[0] : '0;
        else if (bus.core_addr == 2'd1) rdv = m_status();
        push_rx = bus.host_rx_valid && (rx_q.size() < RXD);
        pop_rx  = bus.core_rd && bus.core_addr == 2'd0 && rx_q.size() > 0;
        undf_s  = bus.core_rd && bus.core_addr == 2'd0 && rx_q.size() == 0;
        pop_tx  = bus.host_tx_ready && tx_q.size() > 0;
        push_tx = bus.core_wr && bus.core_addr == 2'd2 && tx_q.size() < TXD;
        ovf_s   = bus.core_wr && bus.core_addr == 2'd2 && tx_q.size() == TXD;
        fl_rx   = bus.core_wr && bus.core_addr == 2'd3 && bus.core_wdata[0];
        fl_tx   = bus.core_wr && bus.core_addr == 2'd3 && bus.core_wdata[1];
        clr     = bus.core_wr && bus.core_addr == 2'd3 && bus.core_wdata[2];
        hd = bus.host_rx_data;
        wd = bus.core_wdata;
        @(posedge clk);
        if (fl_rx) rx_q.delete();
        else begin
            if (pop_rx) void'(rx_q.pop_front());
            if (push_rx) rx_q.push_back(hd);
        end
        if (fl_tx) tx_q.delete();
        else begin
            if (pop_tx) void'(tx_q.pop_front());
            if (push_tx) tx_q.push_back(wd);
        end
        m_ovf  = ovf_s | (m_ovf & !clr);
        m_undf = undf_s | (m_undf & !clr);
        m_irq  = (rx_q.size() >= THR);
        m_rvalid = rv;
        if (rv) m_rdata = rdv;
        #1;
    endtask

    task automatic test_reset();
        idle(); model_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_read: rvalid=%0b rdata=%h, need 0 and 0", bus.core_rvalid, bus.core_rdata);
        end
        vectors++;
        if (bus.host_rx_ready !== 1'b1 || bus.host_tx_valid !== 1'b0 || bus.rx_irq !== 1'b0 || bus.host_tx_data !== '0) begin
            miscompares++;
            $display("FAIL reset_host: rx_ready=%0b tx_valid=%0b irq=%0b tx_data=%h, need 1 0 0 0",
                     bus.host_rx_ready, bus.host_tx_valid, bus.rx_irq, bus.host_tx_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.core_rd = 1'b1; bus.core_addr = 2'd1;
        step(); idle();
        vectors++;
        if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL reset_status: rvalid=%0b rdata=%h, need 1 and 00000004", bus.core_rvalid, bus.core_rdata);
        end
        step();
        vectors++;
        if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL rdata_hold: rvalid=%0b rdata=%h, need 0 and 00000004", bus.core_rvalid, bus.core_rdata);
        end
    endtask

    task automatic test_rx_fill();
        for (int i = 0; i < 5; i++) begin
            bus.host_rx_valid = 1'b1; bus.host_rx_data = DW'(32'hA1 + i);
            step();
            vectors++;
            if (bus.rx_irq !== 1'b1 || bus.host_rx_ready !== (i < 3)) begin
                miscompares++;
                $display("FAIL rx_fill[%0d]: irq=%0b rx_ready=%0b, need 1 and %0b", i, bus.rx_irq, bus.host_rx_ready, i < 3);
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.core_rd = 1'b1; bus.core_addr = 2'd0;
            step();
            vectors++;
            if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== DW'(32'hA1 + i)) begin
                miscompares++;
                $display("FAIL rx_drain[%0d]: rvalid=%0b rdata=%h, need 1 and %h", i, bus.core_rvalid, bus.core_rdata, 32'hA1 + i);
            end
        end
        idle();
        vectors++;
        if (bus.rx_irq !== 1'b0 || bus.host_rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_empty_after: irq=%0b rx_ready=%0b, need 0 and 1", bus.rx_irq, bus.host_rx_ready);
        end
    endtask

    task automatic test_underflow();
        bus.core_rd = 1'b1; bus.core_addr = 2'd0; step();
        bus.core_addr = 2'd1; step();
        vectors++;
        if (bus.core_rdata !== m_status() || bus.core_rdata[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL undf_set: status=%h, need %h with bit4 set", bus.core_rdata, m_status());
        end
        idle();
        bus.core_wr = 1'b1; bus.core_addr = 2'd3; bus.core_wdata = 32'h4; step(); idle();
        bus.core_rd = 1'b1; bus.core_addr = 2'd1; step(); idle();
        vectors++;
        if (bus.core_rdata !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL undf_clear: status=%h, need 00000004", bus.core_rdata);
        end
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < 5; i++) begin
            bus.core_wr = 1'b1; bus.core_addr = 2'd2; bus.core_wdata = DW'(32'h10 + i);
            step();
        end
        idle();
        bus.core_rd = 1'b1; bus.core_addr = 2'd1; step(); idle();
        vectors++;
        if (bus.core_rdata !== 32'h0004_0028) begin
            miscompares++;
            $display("FAIL tx_ovf_status: status=%h, need 00040028", bus.core_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.host_tx_valid !== 1'b1 || bus.host_tx_data !== DW'(32'h10 + i)) begin
                miscompares++;
                $display("FAIL tx_drain[%0d]: valid=%0b data=%h, need 1 and %h", i, bus.host_tx_valid, bus.host_tx_data, 32'h10 + i);
            end
            bus.host_tx_ready = 1'b1; step(); idle();
        end
        vectors++;
        if (bus.host_tx_valid !== 1'b0 || bus.host_tx_data !== '0) begin
            miscompares++;
            $display("FAIL tx_drained: valid=%0b data=%h, need 0 and 0", bus.host_tx_valid, bus.host_tx_data);
        end
        bus.core_wr = 1'b1; bus.core_addr = 2'd3; bus.core_wdata = 32'h4; step(); idle();
    endtask

    task automatic test_simul_rx();
        for (int i = 0; i < 3; i++) begin
            bus.host_rx_valid = 1'b1; bus.host_rx_data = DW'(32'hB0 + i); step();
        end
        idle();
        bus.core_rd = 1'b1; bus.core_addr = 2'd0; step();
        for (int i = 0; i < 2; i++) begin
            bus.host_rx_valid = 1'b1; bus.host_rx_data = DW'(32'hB3 + i);
            bus.core_rd = 1'b1; bus.core_addr = 2'd0;
            step(); idle();
            vectors++;
            if (bus.core_rdata !== DW'(32'hB1 + i) || rx_q.size() != 2) begin
                miscompares++;
                $display("FAIL simul_rx[%0d]: rdata=%h, need %h", i, bus.core_rdata, 32'hB1 + i);
            end
            bus.core_rd = 1'b1; bus.core_addr = 2'd1; step(); idle();
            vectors++;
            if (bus.core_rdata[15:8] !== 8'd2) begin
                miscompares++;
                $display("FAIL simul_rx_count[%0d]: rx_count=%0d, need 2", i, bus.core_rdata[15:8]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            bus.core_rd = 1'b1; bus.core_addr = 2'd0; step(); idle();
            vectors++;
            if (bus.core_rdata !== DW'(32'hB3 + i)) begin
                miscompares++;
                $display("FAIL wrap_read[%0d]: rdata=%h, need %h", i, bus.core_rdata, 32'hB3 + i);
            end
        end
    endtask

    task automatic test_tx_flush();
        for (int i = 0; i < 3; i++) begin
            bus.core_wr = 1'b1; bus.core_addr = 2'd2; bus.core_wdata = DW'(32'h20 + i); step();
        end
        bus.core_wr = 1'b1; bus.core_addr = 2'd3; bus.core_wdata = 32'h2; bus.host_tx_ready = 1'b1;
        step(); idle();
        vectors++;
        if (bus.host_tx_valid !== 1'b0 || bus.host_tx_data !== '0) begin
            miscompares++;
            $display("FAIL tx_flush: valid=%0b data=%h, need 0 and 0", bus.host_tx_valid, bus.host_tx_data);
        end
        bus.core_rd = 1'b1; bus.core_addr = 2'd1; step(); idle();
        vectors++;
        if (bus.core_rdata[23:16] !== 8'd0 || bus.core_rdata[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_flush_status: status=%h, need tx_count 0 and tx_empty", bus.core_rdata);
        end
        bus.core_wr = 1'b1; bus.core_addr = 2'd2; bus.core_wdata = 32'h55; step(); idle();
        vectors++;
        if (bus.host_tx_data !== 32'h55 || bus.host_tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_after_flush: valid=%0b data=%h, need 1 and 00000055", bus.host_tx_valid, bus.host_tx_data);
        end
    endtask

    task automatic test_reset_mid();
        bus.host_rx_valid = 1'b1; bus.host_rx_data = 32'hCC; step(); idle();
        bus.core_rd = 1'b1; bus.core_addr = 2'd1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        idle(); model_reset();
        vectors++;
        if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== '0 || bus.rx_irq !== 1'b0 ||
            bus.host_tx_valid !== 1'b0 || bus.host_rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid: rvalid=%0b rdata=%h irq=%0b tx_valid=%0b rx_ready=%0b, need 0 0 0 0 1",
                     bus.core_rvalid, bus.core_rdata, bus.rx_irq, bus.host_tx_valid, bus.host_rx_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_td;
        for (int c = 0; c < 600; c++) begin
            int sel;
            idle();
            sel = $urandom_range(0, 9);
            bus.core_addr = 2'($urandom_range(0, 3));
            bus.core_rd = (sel < 3);
            bus.core_wr = (sel >= 3 && sel < 6);
            bus.core_wdata = $urandom;
            bus.host_rx_valid = ($urandom_range(0, 1) == 1);
            bus.host_rx_data = $urandom;
            bus.host_tx_ready = ($urandom_range(0, 4) < 2);
            step();
            exp_td = (tx_q.size() > 0) ? tx_q[0] : '0;
            vectors++;
            if (bus.core_rvalid !== m_rvalid || bus.core_rdata !== m_rdata) begin
                miscompares++;
                $display("FAIL rnd_read cyc %0d: rvalid=%0b rdata=%h, need %0b and %h", c, bus.core_rvalid, bus.core_rdata, m_rvalid, m_rdata);
            end
            vectors++;
            if (bus.host_rx_ready !== (rx_q.size() < RXD) || bus.rx_irq !== m_irq) begin
                miscompares++;
                $display("FAIL rnd_rx cyc %0d: rx_ready=%0b irq=%0b, need %0b and %0b", c, bus.host_rx_ready, bus.rx_irq, rx_q.size() < RXD, m_irq);
            end
            vectors++;
            if (bus.host_tx_valid !== (tx_q.size() > 0) || bus.host_tx_data !== exp_td) begin
                miscompares++;
                $display("FAIL rnd_tx cyc %0d: valid=%0b data=%h, need %0b and %h", c, bus.host_tx_valid, bus.host_tx_data, tx_q.size() > 0, exp_td);
            end
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, need completion within 200000 time units");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rx_fill();
        test_underflow();
        test_tx_overflow();
        test_simul_rx();
        test_tx_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
